// File: rtl/lsu_mem_port.sv
// Load/store memory port: turns one decoded load/store request into one or two
// word-aligned, byte-enabled bus beats and returns a single extended response.
module lsu_mem_port #(
    parameter int TIMEOUT_CYC = 255,
    parameter bit SPLIT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    localparam logic [31:0] TO_LAST = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic        rd_q;
    logic        split_q;
    logic [31:0] rd_lo;
    logic [3:0]  be_hi;
    logic [31:0] wd_hi;
    logic [31:0] wait_cnt;

    logic [1:0]  off_in;
    logic [3:0]  be_base;
    logic [7:0]  be8;
    logic [63:0] wd64;
    logic        mis_in;
    logic        err_in;
    logic        to_hit;

    // Shift the merged read window down to the access offset, then extend.
    function automatic logic [31:0] load_data(input logic [63:0] r64, input logic [1:0] off,
                                              input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        v = 32'(r64 >> {off, 3'b000});
        case (sz)
            2'b00:   return {{24{sx & v[7]}}, v[7:0]};
            2'b01:   return {{16{sx & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    always_comb begin
        off_in = addr[1:0];
        case (size)
            2'b00:   be_base = 4'b0001;
            2'b01:   be_base = 4'b0011;
            2'b10:   be_base = 4'b1111;
            default: be_base = 4'b0000;
        endcase
        be8    = {4'b0000, be_base} << off_in;
        wd64   = {32'b0, wdata} << {off_in, 3'b000};
        mis_in = ((size == 2'b01) && (off_in == 2'b11)) || ((size == 2'b10) && (off_in != 2'b00));
        err_in = (size == 2'b11) || (wr_en == rd_en) || (mis_in && !SPLIT_EN);
        to_hit = (TIMEOUT_CYC != 0) && (wait_cnt == TO_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            off_q      <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            rd_q       <= 1'b0;
            split_q    <= 1'b0;
            rd_lo      <= '0;
            be_hi      <= '0;
            wd_hi      <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        off_q     <= off_in;
                        size_q    <= size;
                        sign_q    <= sign_ext;
                        rd_q      <= rd_en;
                        split_q   <= mis_in;
                        be_hi     <= be8[7:4];
                        wd_hi     <= wd64[63:32];
                        wait_cnt  <= '0;
                        if (err_in) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            rdata      <= '0;
                        end else begin
                            state     <= BEAT0;
                            mem_req   <= 1'b1;
                            mem_we    <= wr_en;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be8[3:0];
                            mem_wdata <= wd64[31:0];
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (mem_ack && state == BEAT0 && split_q) begin
                        state     <= BEAT1;
                        rd_lo     <= mem_rdata;
                        wait_cnt  <= '0;
                        mem_addr  <= mem_addr + 32'd4;
                        mem_be    <= be_hi;
                        mem_wdata <= wd_hi;
                    end else if (mem_ack || to_hit) begin
                        // Final beat done, or beat timed out: release the bus and respond.
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= '0;
                        mem_be     <= '0;
                        mem_wdata  <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= !mem_ack;
                        if (mem_ack && rd_q)
                            rdata <= (state == BEAT1) ? load_data({mem_rdata, rd_lo}, off_q, size_q, sign_q)
                                                      : load_data({32'b0, mem_rdata}, off_q, size_q, sign_q);
                        else
                            rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    rdata      <= '0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: inputs driven and outputs sampled on the falling edge.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign_ext;
    logic        wr_en;
    logic        rd_en;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu_mem_port #(.TIMEOUT_CYC(4), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .wdata(wdata), .size(size), .sign_ext(sign_ext),
        .wr_en(wr_en), .rd_en(rd_en), .resp_valid(resp_valid), .resp_err(resp_err),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Presents a request for one cycle; returns on the falling edge after acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                         input logic se, input logic we, input logic re);
        @(negedge clk);
        req_valid = 1'b1; addr = a; wdata = wd; size = sz; sign_ext = se; wr_en = we; rd_en = re;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rd);
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; addr = 0; wdata = 0; size = 0; sign_ext = 0;
        wr_en = 0; rd_en = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        checks++; if ({mem_be, mem_addr, rdata} !== 68'd0) begin errors++; $display("FAIL rst_outputs got=%h exp=0", {mem_be, mem_addr, rdata}); end
        rst_n = 1'b1;
    endtask

    task automatic test_byte_load();
        issue(32'h103, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lb_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lb_addr got=%h exp=%h", mem_addr, 32'h100); end
        checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL lb_be got=%b exp=1000", mem_be); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL lb_we got=%b exp=0", mem_we); end
        ack(32'h80112233);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL lb_resp got=%b%b exp=10", resp_valid, resp_err); end
        checks++; if (rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got=%h exp=FFFFFF80", rdata); end
        issue(32'h103, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
        ack(32'h80112233);
        checks++; if (rdata !== 32'h00000080 || resp_valid !== 1'b1) begin errors++; $display("FAIL lbu_rdata got=%h exp=00000080", rdata); end
    endtask

    task automatic test_store_word();
        issue(32'h200, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1, 1'b0);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL sw_t1 got=%b%b exp=00", resp_valid, req_ready); end
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL sw_req_we got=%b%b exp=11", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h200 || mem_be !== 4'b1111) begin errors++; $display("FAIL sw_addr_be got=%h/%b exp=200/1111", mem_addr, mem_be); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=DEADBEEF", mem_wdata); end
        ack(32'h0);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL sw_resp got=%b%b %h exp=10 0", resp_valid, resp_err, rdata); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sw_req_drop got=%b exp=0", mem_req); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL sw_after got=%b%b exp=01", resp_valid, req_ready); end
    endtask

    task automatic test_split_load();
        issue(32'h102, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1);
        checks++; if (mem_addr !== 32'h100 || mem_be !== 4'b1100) begin errors++; $display("FAIL lw_b0 got=%h/%b exp=100/1100", mem_addr, mem_be); end
        ack(32'h44332211);
        checks++; if (mem_req !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL lw_b1_req got=%b%b exp=10", mem_req, resp_valid); end
        checks++; if (mem_addr !== 32'h104 || mem_be !== 4'b0011) begin errors++; $display("FAIL lw_b1 got=%h/%b exp=104/0011", mem_addr, mem_be); end
        ack(32'h88776655);
        checks++; if (resp_valid !== 1'b1 || rdata !== 32'h66554433) begin errors++; $display("FAIL lw_rdata got=%b %h exp=1 66554433", resp_valid, rdata); end
        issue(32'h103, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1);
        checks++; if (mem_addr !== 32'h100 || mem_be !== 4'b1000) begin errors++; $display("FAIL lh_b0 got=%h/%b exp=100/1000", mem_addr, mem_be); end
        ack(32'h44332211);
        checks++; if (mem_addr !== 32'h104 || mem_be !== 4'b0001) begin errors++; $display("FAIL lh_b1 got=%h/%b exp=104/0001", mem_addr, mem_be); end
        ack(32'h88776655);
        checks++; if (resp_valid !== 1'b1 || rdata !== 32'h00005544) begin errors++; $display("FAIL lh_rdata got=%b %h exp=1 00005544", resp_valid, rdata); end
    endtask

    task automatic test_split_store_wrap();
        issue(32'hFFFFFFFF, 32'h0000ABCD, 2'b01, 1'b0, 1'b1, 1'b0);
        checks++; if (mem_addr !== 32'hFFFFFFFC || mem_be !== 4'b1000) begin errors++; $display("FAIL sh_b0 got=%h/%b exp=FFFFFFFC/1000", mem_addr, mem_be); end
        checks++; if (mem_wdata !== 32'hCD000000 || mem_we !== 1'b1) begin errors++; $display("FAIL sh_b0_wd got=%h we=%b exp=CD000000 we=1", mem_wdata, mem_we); end
        ack(32'h0);
        checks++; if (mem_addr !== 32'h00000000 || mem_be !== 4'b0001) begin errors++; $display("FAIL sh_b1 got=%h/%b exp=00000000/0001", mem_addr, mem_be); end
        checks++; if (mem_wdata !== 32'h000000AB || mem_req !== 1'b1) begin errors++; $display("FAIL sh_b1_wd got=%h req=%b exp=000000AB req=1", mem_wdata, mem_req); end
        ack(32'h0);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL sh_resp got=%b%b %h exp=10 0", resp_valid, resp_err, rdata); end
    endtask

    task automatic test_errors();
        int n;
        issue(32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL to_req_cycles got=%0d exp=4", n); end
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL to_resp got=%b%b %h exp=11 0", resp_valid, resp_err, rdata); end
        issue(32'h40, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL sz11 got=v%b e%b r%b exp=v1 e1 r0", resp_valid, resp_err, mem_req); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL sz11_after got=r%b v%b exp=r0 v0", mem_req, resp_valid); end
        issue(32'h40, 32'h0, 2'b10, 1'b0, 1'b1, 1'b1);
        checks++; if (resp_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL wr_rd_both got=e%b r%b exp=e1 r0", resp_err, mem_req); end
        @(negedge clk);
        ack(32'hFFFFFFFF);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL late_ack got=v%b rdy%b r%b exp=v0 rdy1 r0", resp_valid, req_ready, mem_req); end
    endtask

    task automatic test_reset_mid_access();
        issue(32'h102, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1);
        ack(32'h44332211);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin errors++; $display("FAIL rm_beat1 got=r%b %h exp=r1 104", mem_req, mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rm_async got=r%b rdy%b exp=r0 rdy1", mem_req, req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rm_no_resp got=v%b r%b exp=v0 r0", resp_valid, mem_req); end
        issue(32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || mem_be !== 4'b1111) begin errors++; $display("FAIL rm_lw_beat got=r%b %h %b exp=r1 20 1111", mem_req, mem_addr, mem_be); end
        ack(32'h12345678);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || rdata !== 32'h12345678) begin errors++; $display("FAIL rm_lw_resp got=%b%b %h exp=10 12345678", resp_valid, resp_err, rdata); end
    endtask

    initial begin
        test_reset();
        test_byte_load();
        test_store_word();
        test_split_load();
        test_split_store_wrap();
        test_errors();
        test_reset_mid_access();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
